// File: rtl/output_drain_controller_if.sv
// Output drain controller bus.
// Groups the job configuration, the tile handshake with the array, and the
// drive signals to the output address generator.
//   master : host / array side; drives start, cfg_*, tile_valid and
//            observes on, base_addr, num_cols, tile_ack, busy, done.
//   slave  : the drain controller itself (reverse directions).
interface output_drain_controller_if #(
  parameter int RAM_O_SIZE = 256,
  parameter int ARRAY_M    = 8,
  parameter int ARRAY_N    = 8,
  parameter int MAX_TILES  = 16,
  parameter int ADDR_WIDTH = $clog2(RAM_O_SIZE),
  parameter int TILE_W     = $clog2(MAX_TILES) + 1
);
  localparam int ROW_W = $clog2(ARRAY_N) + 1;
  localparam int COL_W = $clog2(ARRAY_M) + 1;

  logic                  start;
  logic [ADDR_WIDTH-1:0] cfg_base_addr;
  logic [ADDR_WIDTH-1:0] cfg_stride;
  logic [TILE_W-1:0]     cfg_num_tiles;
  logic [ROW_W-1:0]      cfg_num_rows;
  logic [COL_W-1:0]      cfg_num_cols;
  logic                  tile_valid;

  logic                  on;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [COL_W-1:0]      num_cols;
  logic                  tile_ack;
  logic                  busy;
  logic                  done;

  modport master (
    output start, cfg_base_addr, cfg_stride, cfg_num_tiles, cfg_num_rows,
           cfg_num_cols, tile_valid,
    input  on, base_addr, num_cols, tile_ack, busy, done
  );

  modport slave (
    input  start, cfg_base_addr, cfg_stride, cfg_num_tiles, cfg_num_rows,
           cfg_num_cols, tile_valid,
    output on, base_addr, num_cols, tile_ack, busy, done
  );
endinterface

// File: rtl/output_drain_controller.sv
// Output drain controller.
// Sequences the draining of finished array tiles into the output RAM: for
// each tile it waits for tile_valid, holds 'on' high for num_rows cycles to
// run the output address generator, inserts a one-cycle gap (tile_ack) that
// lets the generator's address counter return to zero, then advances the
// tile base address by the stride. After the last tile it pulses done.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : output_drain_controller_if.slave (start/cfg_*/tile_valid in,
//           on/base_addr/num_cols/tile_ack/busy/done out)
module output_drain_controller #(
  parameter int RAM_O_SIZE = 256,
  parameter int ARRAY_M    = 8,
  parameter int ARRAY_N    = 8,
  parameter int MAX_TILES  = 16,
  parameter int ADDR_WIDTH = $clog2(RAM_O_SIZE),
  parameter int TILE_W     = $clog2(MAX_TILES) + 1
) (
  input logic                      clk,
  input logic                      reset,
  output_drain_controller_if.slave bus
);
  localparam int ROW_W = $clog2(ARRAY_N) + 1;
  localparam int COL_W = $clog2(ARRAY_M) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN,
    ST_GAP,
    ST_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [TILE_W-1:0]     num_tiles_q;
  logic [ROW_W-1:0]      num_rows_q;
  logic [COL_W-1:0]      num_cols_q;
  logic [TILE_W-1:0]     tile_cnt_q;
  logic [ROW_W-1:0]      row_cnt_q;

  logic                  last_row;
  logic [TILE_W-1:0]     tile_next;
  logic                  cfg_empty;

  assign last_row  = (row_cnt_q == num_rows_q - ROW_W'(1));
  assign tile_next = tile_cnt_q + TILE_W'(1);
  // An empty job is decided from the live cfg values on the start edge,
  // which are exactly the values being latched.
  assign cfg_empty = (bus.cfg_num_tiles == '0) || (bus.cfg_num_rows == '0);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = cfg_empty ? ST_FIN : ST_WAIT;
      ST_WAIT:  if (bus.tile_valid) state_d = ST_DRAIN;
      ST_DRAIN: if (last_row) state_d = ST_GAP;
      // The gap is never skipped: the generator only clears its address
      // counter while 'on' is low.
      ST_GAP:   state_d = (tile_next < num_tiles_q) ? ST_WAIT : ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      stride_q    <= '0;
      num_tiles_q <= '0;
      num_rows_q  <= '0;
      num_cols_q  <= '0;
      tile_cnt_q  <= '0;
      row_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          // Configuration is captured only here, so cfg_* and start are
          // don't-care for the rest of the job.
          if (bus.start) begin
            base_q      <= bus.cfg_base_addr;
            stride_q    <= bus.cfg_stride;
            num_tiles_q <= bus.cfg_num_tiles;
            num_rows_q  <= bus.cfg_num_rows;
            num_cols_q  <= bus.cfg_num_cols;
            tile_cnt_q  <= '0;
          end
        end
        ST_WAIT:  if (bus.tile_valid) row_cnt_q <= '0;
        ST_DRAIN: row_cnt_q <= row_cnt_q + ROW_W'(1);
        ST_GAP: begin
          // base_addr held through the gap because the generator's final
          // write of the tile lands there; it advances on the exit edge.
          base_q     <= base_q + stride_q;
          tile_cnt_q <= tile_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.on        = (state_q == ST_DRAIN);
  assign bus.tile_ack  = (state_q == ST_GAP);
  assign bus.done      = (state_q == ST_FIN);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.base_addr = base_q;
  assign bus.num_cols  = num_cols_q;
endmodule
